fibo_seq_checker: RTL and testbench

- Downstream consumer of the 4-bit Fibonacci generator output.
- Samples each presented term and checks the recurrence f[n] = f[n-1] + f[n-2] mod 2^WIDTH.
- Tracks term count, modular wrap-arounds and mismatches; used as an on-chip self-check and monitor behind the generator.

---
 rtl/fibo_pkg.sv | 16 +
 rtl/fibo_seq_checker_if.sv | 31 +++
 rtl/fibo_seq_checker_sat_counter.sv | 33 +++
 rtl/fibo_seq_checker.sv | 127 ++++++++++++
 tb/tb_fibo_seq_checker.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci generator/checker pair: FSM states,
// default term width and the generator seed constants.
package fibo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED1 = 2'd1,
    TRACK = 2'd2,
    ERROR = 2'd3
  } fibo_state_e;

  localparam int FIBO_W = 4;
  localparam logic [FIBO_W-1:0] FIBO_SEED0 = 4'd0;
  localparam logic [FIBO_W-1:0] FIBO_SEED1 = 4'd1;

endpackage

// File: rtl/fibo_seq_checker_if.sv
// Term stream plus status/counter bundle between a Fibonacci source (master)
// and the sequence checker (slave).
interface fibo_seq_checker_if
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_W,
  parameter int CNT_W = 8
);

  logic             term_valid;
  logic [WIDTH-1:0] term_in;
  logic             clear;
  logic             locked;
  logic             err;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [CNT_W-1:0] term_count;
  logic [CNT_W-1:0] wrap_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output term_valid, term_in, clear,
    input  locked, err, err_pulse, wrap_pulse, term_count, wrap_count, err_count
  );

  modport slave (
    input  term_valid, term_in, clear,
    output locked, err, err_pulse, wrap_pulse, term_count, wrap_count, err_count
  );

endinterface

// File: rtl/fibo_seq_checker_sat_counter.sv
// Saturating event counter with synchronous clear (priority over inc) and
// asynchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fibo_seq_checker.sv
// Checks f[n] = f[n-1] + f[n-2] mod 2^WIDTH on a qualified term stream.
// Define FIBO_CHK_RESYNC_EN to reseed on a mismatch instead of locking in ERROR.
module fibo_seq_checker
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_W,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  fibo_seq_checker_if.slave   bus
);

  fibo_state_e      state_r, state_s;
  logic [WIDTH-1:0] prev1_r, prev1_s;
  logic [WIDTH-1:0] prev2_r, prev2_s;
  logic [WIDTH:0]   sum_s;
  logic             accept_s, check_s, carry_s, mismatch_s;
  logic             locked_r, locked_s;
  logic             err_r, err_s;
  logic             err_pulse_r, err_pulse_s;
  logic             wrap_pulse_r, wrap_pulse_s;

  assign sum_s      = {1'b0, prev1_r} + {1'b0, prev2_r};
  assign carry_s    = sum_s[WIDTH];
  assign mismatch_s = (bus.term_in != sum_s[WIDTH-1:0]);
  assign accept_s   = bus.term_valid && !bus.clear;
  assign check_s    = accept_s && (state_r == TRACK);

  // State and seed-history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      prev1_r <= {WIDTH{1'b0}};
      prev2_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      prev1_r <= prev1_s;
      prev2_r <= prev2_s;
    end
  end

  // Next-state and history update; clear discards any term in the same cycle.
  always_comb begin
    state_s = state_r;
    prev1_s = prev1_r;
    prev2_s = prev2_r;
    if (bus.clear) begin
      state_s = IDLE;
      prev1_s = {WIDTH{1'b0}};
      prev2_s = {WIDTH{1'b0}};
    end else if (bus.term_valid) begin
      case (state_r)
        IDLE: begin
          prev2_s = bus.term_in;
          state_s = SEED1;
        end
        SEED1: begin
          prev1_s = bus.term_in;
          state_s = TRACK;
        end
        TRACK: begin
          if (mismatch_s) begin
`ifdef FIBO_CHK_RESYNC_EN
            prev2_s = bus.term_in;
            state_s = SEED1;
`else
            state_s = ERROR;
`endif
          end else begin
            prev2_s = prev1_r;
            prev1_s = bus.term_in;
          end
        end
        ERROR:   state_s = ERROR;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Next values of the status outputs, aligned with the state update.
  always_comb begin
    locked_s     = (state_s == TRACK);
    err_pulse_s  = check_s && mismatch_s;
    wrap_pulse_s = check_s && carry_s;
    if (bus.clear) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r || (check_s && mismatch_s);
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked_r     <= 1'b0;
      err_r        <= 1'b0;
      err_pulse_r  <= 1'b0;
      wrap_pulse_r <= 1'b0;
    end else begin
      locked_r     <= locked_s;
      err_r        <= err_s;
      err_pulse_r  <= err_pulse_s;
      wrap_pulse_r <= wrap_pulse_s;
    end
  end

  assign bus.locked     = locked_r;
  assign bus.err        = err_r;
  assign bus.err_pulse  = err_pulse_r;
  assign bus.wrap_pulse = wrap_pulse_r;

  sat_counter #(.CNT_W(CNT_W)) u_term_cnt (
    .clk(clk), .rst_n(reset), .clr(bus.clear), .inc(accept_s), .count(bus.term_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
    .clk(clk), .rst_n(reset), .clr(bus.clear), .inc(check_s && carry_s), .count(bus.wrap_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .rst_n(reset), .clr(bus.clear), .inc(check_s && mismatch_s), .count(bus.err_count)
  );

endmodule

// File: tb/tb_fibo_seq_checker.sv
// Scoreboard bench: directed term vectors with hand-computed responses; a
// second checker with 2-bit counters shadows the stream to exercise saturation.
module tb_fibo_seq_checker;

  typedef struct {
    logic lk, er, ep, wp;
    int   tc, wc, ec;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   step;
  exp_t exp_q[$];

  fibo_seq_checker_if #(.WIDTH(4), .CNT_W(8)) bus ();
  fibo_seq_checker_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  assign bus2.term_valid = bus.term_valid;
  assign bus2.term_in    = bus.term_in;
  assign bus2.clear      = bus.clear;

  fibo_seq_checker #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  fibo_seq_checker #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, req);
    end
  endfunction

  function automatic int sat3(int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Monitor: outputs are compared one cycle after each sampled stimulus.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      step++;
      chk("locked",     int'(bus.locked),     int'(e.lk));
      chk("err",        int'(bus.err),        int'(e.er));
      chk("err_pulse",  int'(bus.err_pulse),  int'(e.ep));
      chk("wrap_pulse", int'(bus.wrap_pulse), int'(e.wp));
      chk("term_count", int'(bus.term_count), e.tc);
      chk("wrap_count", int'(bus.wrap_count), e.wc);
      chk("err_count",  int'(bus.err_count),  e.ec);
      chk("sat_term_count", int'(bus2.term_count), sat3(e.tc));
      chk("sat_wrap_count", int'(bus2.wrap_count), sat3(e.wc));
    end
  end

  task automatic apply(input logic v, input logic [3:0] t, input logic c,
                       input logic lk, input logic er, input logic ep, input logic wp,
                       input int tc, input int wc, input int ec);
    exp_t e;
    bus.term_valid = v;
    bus.term_in    = t;
    bus.clear      = c;
    e.lk = lk; e.er = er; e.ep = ep; e.wp = wp;
    e.tc = tc; e.wc = wc; e.ec = ec;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle_inputs();
    bus.term_valid = 1'b0;
    bus.term_in    = 4'd0;
    bus.clear      = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_locked"},     int'(bus.locked),     0);
    chk({tag, "_err"},        int'(bus.err),        0);
    chk({tag, "_err_pulse"},  int'(bus.err_pulse),  0);
    chk({tag, "_wrap_pulse"}, int'(bus.wrap_pulse), 0);
    chk({tag, "_term_count"}, int'(bus.term_count), 0);
    chk({tag, "_wrap_count"}, int'(bus.wrap_count), 0);
    chk({tag, "_err_count"},  int'(bus.err_count),  0);
    chk({tag, "_sat_term"},   int'(bus2.term_count), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    step   = 0;
    reset  = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    // Generator sequence, including wraps at 8+13, 13+5 and 9+7.
    apply(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 0);
    apply(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2,  0, 0);
    apply(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3,  0, 0);
    apply(1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4,  0, 0);
    apply(1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5,  0, 0);
    apply(1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6,  0, 0);
    apply(1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7,  0, 0);
    apply(1'b1, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8,  0, 0);
    apply(1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9,  1, 0);
    apply(1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9,  1, 0);
    apply(1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, 2, 0);
    apply(1'b1, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11, 2, 0);
    apply(1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12, 2, 0);
    apply(1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 13, 3, 0);
    apply(1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14, 3, 0);

    // Clear together with a valid term: the term is discarded.
    apply(1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 0);

    // Mismatch: 4 where 3 is expected.
    apply(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 0);
    apply(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2,  0, 0);
    apply(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3,  0, 0);
    apply(1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4,  0, 0);
    apply(1'b1, 4'd4,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5,  0, 1);
`ifdef FIBO_CHK_RESYNC_EN
    apply(1'b1, 4'd6,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6,  0, 1);
    apply(1'b1, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7,  0, 1);
    apply(1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8,  1, 1);
`else
    apply(1'b1, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6,  0, 1);
    apply(1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7,  0, 1);
    apply(1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8,  0, 1);
`endif
    apply(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 0);

    // Lock, then pull reset low between edges.
    apply(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 0);
    apply(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2,  0, 0);
    apply(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3,  0, 0);
    idle_inputs();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    apply(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 0);
    apply(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2,  0, 0);
    apply(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3,  0, 0);
    apply(1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4,  0, 0);
    idle_inputs();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
